// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
//   cplx_t     : one complex sample {re, im} at the default width
//   rd_state_t : read-side FSM states
//   bitrev()   : reverses the low log2n bits of an index
package fft_pkg;

  localparam int unsigned FFT_DW    = 24;
  localparam int unsigned FFT_LOG2N = 4;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned log2n);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < log2n; b++) begin
      r[log2n-1-b] = idx[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer: one synchronous write port, one asynchronous read port.
//   i_clk                          : clock
//   i_we/i_wr_bank/i_wr_addr/i_wr_data : write port
//   i_rd_bank/i_rd_addr            : read address
//   o_rd_data                      : combinational read data
// Contents are not reset; occupancy is tracked by the controller.
module fft_pingpong_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 48
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [0:2**(AW+1)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[{i_rd_bank, i_rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed SDF FFT output frames into natural order.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid, din_r/din_i : unstallable bit-reversed input samples
//   dout_r/dout_i, out_valid, out_ready, out_last : natural-order output stream
//   overflow              : sticky, set when a sample is dropped (both banks full)
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = FFT_LOG2N,
  parameter int unsigned DW    = FFT_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 overflow
);

  localparam logic [LOG2N-1:0] LastIdx = '1;

  logic [LOG2N-1:0]    r_wr_idx, r_rd_idx;
  logic                r_wr_bank, r_rd_bank;
  logic [1:0]          r_bank_full;
  rd_state_t           r_state;
  logic signed [DW-1:0] r_dout_r, r_dout_i;
  logic                r_out_valid, r_overflow;

  logic                w_accept, w_release, w_writable, w_we, w_load;
  logic [LOG2N-1:0]    w_wr_addr, w_rd_addr, w_rd_idx_d;
  logic                w_rd_bank, w_rd_bank_d, w_valid_d;
  logic [1:0]          w_bank_full_d;
  rd_state_t           w_state_d;
  logic [2*DW-1:0]     w_rd_data;

  always_comb begin
    w_accept   = r_out_valid & out_ready;
    w_release  = w_accept & (r_rd_idx == LastIdx);
    // A bank drained on this very edge may be refilled on the same edge.
    w_writable = ~r_bank_full[r_wr_bank] | (w_release & (r_rd_bank == r_wr_bank));
    w_we       = in_valid & w_writable;
    w_wr_addr  = LOG2N'(bitrev(32'(r_wr_idx), LOG2N));
  end

  always_comb begin
    w_bank_full_d = r_bank_full;
    if (w_release) w_bank_full_d[r_rd_bank] = 1'b0;
    if (w_we && (r_wr_idx == LastIdx)) w_bank_full_d[r_wr_bank] = 1'b1;
  end

  // Read side: w_rd_bank/w_rd_addr select the entry loaded on w_load.
  always_comb begin
    w_load      = 1'b0;
    w_rd_bank   = r_rd_bank;
    w_rd_addr   = '0;
    w_rd_bank_d = r_rd_bank;
    w_rd_idx_d  = r_rd_idx;
    w_valid_d   = r_out_valid;
    w_state_d   = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_bank_full[r_rd_bank]) begin
          w_load    = 1'b1;
          w_valid_d = 1'b1;
          w_state_d = STREAM;
        end
      end
      STREAM: begin
        if (w_accept) begin
          if (r_rd_idx != LastIdx) begin
            w_rd_addr  = r_rd_idx + 1'b1;
            w_rd_idx_d = r_rd_idx + 1'b1;
            w_load     = 1'b1;
          end else begin
            w_rd_bank   = ~r_rd_bank;
            w_rd_bank_d = ~r_rd_bank;
            w_rd_idx_d  = '0;
            if (r_bank_full[~r_rd_bank]) begin
              w_load = 1'b1;
            end else begin
              w_valid_d = 1'b0;
              w_state_d = IDLE;
            end
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  fft_pingpong_ram #(
    .AW(LOG2N),
    .W (2*DW)
  ) u_ram (
    .i_clk    (clk),
    .i_we     (w_we),
    .i_wr_bank(r_wr_bank),
    .i_wr_addr(w_wr_addr),
    .i_wr_data({din_r, din_i}),
    .i_rd_bank(w_rd_bank),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_idx    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_idx    <= '0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_state     <= IDLE;
      r_dout_r    <= '0;
      r_dout_i    <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_bank_full <= w_bank_full_d;
      r_rd_idx    <= w_rd_idx_d;
      r_rd_bank   <= w_rd_bank_d;
      r_state     <= w_state_d;
      r_out_valid <= w_valid_d;
      if (w_we) begin
        r_wr_idx <= r_wr_idx + 1'b1;  // wraps to 0 after N-1
        if (r_wr_idx == LastIdx) r_wr_bank <= ~r_wr_bank;
      end
      if (in_valid && !w_writable) r_overflow <= 1'b1;
      if (w_load) begin
        r_dout_r <= w_rd_data[2*DW-1:DW];
        r_dout_i <= w_rd_data[DW-1:0];
      end
    end
  end

  assign dout_r    = r_dout_r;
  assign dout_i    = r_dout_i;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_valid & (r_rd_idx == LastIdx);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int unsigned LOG2N = 4;
  localparam int unsigned DW    = 24;
  localparam int unsigned N     = 16;

  logic clk, reset, in_valid, out_ready, out_valid, out_last, overflow;
  logic signed [DW-1:0] din_r, din_i, dout_r, dout_i;

  fft_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .din_r    (din_r),
    .din_i    (din_i),
    .dout_r   (dout_r),
    .dout_i   (dout_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame FIFO of depth two. Complete frames sit in exp_q
  // in natural order; the frame being received is assembled in part[].
  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    bit            last;
  } samp_t;

  samp_t exp_q[$];
  samp_t part[N];
  int    part_cnt;
  bit    exp_valid, exp_ovf;
  int    n_assert, n_fail, dut_out, dut_last;

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < int'(LOG2N); b++) if ((k >> b) % 2 == 1) r += 1 << (int'(LOG2N) - 1 - b);
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    part_cnt  = 0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    n_assert++;
    assert (out_valid === 1'b0 && out_last === 1'b0 && overflow === 1'b0 &&
            dout_r === '0 && dout_i === '0) else begin
      n_fail++;
      $error("FAIL %s: observed valid=%0b last=%0b ovf=%0b r=%0d i=%0d expected all zero",
             tag, out_valid, out_last, overflow, dout_r, dout_i);
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic cycle(input bit v, input logic [DW-1:0] r, input logic [DW-1:0] im,
                       input bit rdy);
    bit hs;
    int nfull;
    in_valid  = v;
    din_r     = r;
    din_i     = im;
    out_ready = rdy;
    #1;
    n_assert++;
    assert (out_valid === exp_valid) else begin
      n_fail++;
      $error("FAIL out_valid: observed %0b expected %0b", out_valid, exp_valid);
    end
    n_assert++;
    assert (overflow === exp_ovf) else begin
      n_fail++;
      $error("FAIL overflow: observed %0b expected %0b", overflow, exp_ovf);
    end
    if (exp_valid && exp_q.size() > 0) begin
      n_assert++;
      assert (dout_r === exp_q[0].r && dout_i === exp_q[0].i && out_last === exp_q[0].last)
      else begin
        n_fail++;
        $error("FAIL data: observed r=%0d i=%0d last=%0b expected r=%0d i=%0d last=%0b",
               dout_r, dout_i, out_last, $signed(exp_q[0].r), $signed(exp_q[0].i),
               exp_q[0].last);
      end
    end else begin
      n_assert++;
      assert (out_last === 1'b0) else begin
        n_fail++;
        $error("FAIL out_last idle: observed %0b expected 0", out_last);
      end
    end
    if (out_valid === 1'b1 && rdy) begin
      dut_out++;
      if (out_last === 1'b1) dut_last++;
    end
    // Model update for this edge: output side first, so a frame drained now
    // frees its slot for an input arriving on the same edge.
    hs = exp_valid && rdy;
    if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
    exp_valid = (exp_q.size() != 0);
    if (v) begin
      nfull = (exp_q.size() + int'(N) - 1) / int'(N);
      if (part_cnt != 0 || nfull < 2) begin
        part[rev(part_cnt)] = '{r: r, i: im, last: (rev(part_cnt) == int'(N) - 1)};
        part_cnt++;
        if (part_cnt == int'(N)) begin
          for (int j = 0; j < int'(N); j++) exp_q.push_back(part[j]);
          part_cnt = 0;
        end
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset state");
    reset = 1'b0;
    model_clear();
    dut_out  = 0;
    dut_last = 0;
  endtask

  // Asserts reset between edges while inputs are live.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_zero(tag);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    dut_out  = 0;
    dut_last = 0;
  endtask

  task automatic rand_frame(input bit rdy);
    for (int k = 0; k < int'(N); k++) cycle(1'b1, DW'($urandom), DW'($urandom), rdy);
  endtask

  task automatic drain(input int max, input bit toggle);
    int c = 0;
    while ((exp_q.size() > 0 || exp_valid) && c < max) begin
      cycle(1'b0, '0, '0, toggle ? (c % 2 == 0) : 1'b1);
      c++;
    end
    check_int("drain bound", exp_q.size(), 0);
    cycle(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
    @(negedge clk);
    do_reset();

    // Single frame with index-coded data.
    for (int k = 0; k < int'(N); k++) cycle(1'b1, DW'(rev(k)), DW'(-rev(k)), 1'b1);
    drain(40, 1'b0);
    check_int("single count", dut_out, 16);
    check_int("single last", dut_last, 1);

    // Four back-to-back frames.
    do_reset();
    for (int f = 0; f < 4; f++) rand_frame(1'b1);
    drain(60, 1'b0);
    check_int("b2b count", dut_out, 64);
    check_int("b2b overflow", int'(overflow), 0);

    // Backpressure toggling every cycle.
    do_reset();
    for (int k = 0; k < int'(N); k++) cycle(1'b1, DW'($urandom), DW'($urandom), (k % 2 == 0));
    drain(100, 1'b1);
    check_int("bp count", dut_out, 16);
    check_int("bp last once", dut_last, 1);

    // Overflow: three frames with no drain.
    do_reset();
    for (int f = 0; f < 3; f++) rand_frame(1'b0);
    check_int("ovf sticky", int'(overflow), 1);
    drain(80, 1'b0);
    check_int("ovf count", dut_out, 32);

    // Release of bank 0 on the same edge as its refill starts.
    do_reset();
    for (int c = 0; c < 48; c++) cycle(1'b1, DW'($urandom), DW'($urandom), (c >= 17));
    drain(80, 1'b0);
    check_int("relwr count", dut_out, 48);
    check_int("relwr overflow", int'(overflow), 0);

    // Reset during input index 7.
    do_reset();
    for (int k = 0; k < 7; k++) cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1);
    in_valid = 1'b1;
    din_r    = DW'($urandom);
    async_reset("reset mid input");
    rand_frame(1'b1);
    drain(40, 1'b0);
    check_int("post reset1 count", dut_out, 16);

    // Reset while output index 5 is presented.
    do_reset();
    rand_frame(1'b1);
    for (int c = 0; c < 40 && dut_out < 5; c++) cycle(1'b0, '0, '0, 1'b1);
    check_int("pre reset2 count", dut_out, 5);
    async_reset("reset mid output");
    rand_frame(1'b1);
    drain(40, 1'b0);
    check_int("post reset2 count", dut_out, 16);
    check_int("post reset2 last", dut_last, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side reader for the radix-2 SDF FFT pipeline. The delay-line stages write results in bit-reversed index order, one complex sample per in_valid cycle, with no stall.
- This block buffers each N-point frame in a ping-pong memory and re-emits it in natural index order over a valid/ready stream toward the RS5 accelerator interface.

Parameters:
- LOG2N, 4, log2 of FFT length; N = 2**LOG2N points per frame.
- DW, 24, signed width of each real/imag component.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  one pipeline sample present this cycle; never stalled.
- din_r  in  DW  signed real part, bit-reversed order.
- din_i  in  DW  signed imaginary part, bit-reversed order.
- dout_r  out  DW  signed real part, natural order.
- dout_i  out  DW  signed imaginary part, natural order.
- out_valid  out  1  dout_r/dout_i/out_last hold a valid sample.
- out_ready  in  1  downstream accepts the sample when out_valid && out_ready.
- out_last  out  1  high with sample index N-1 of a frame.
- overflow  out  1  sticky; a sample was dropped because both banks were full.

Behaviour:
- Reset: all outputs 0; wr_idx=0, wr_bank=0, rd_idx=0, rd_bank=0; both bank_full=0; FSM IDLE. Memory contents are don't-care. Reset asserted mid-frame discards all buffered data.
- Storage: two banks of N entries, each entry {re,im} of 2*DW bits.
- Write side:
  - On an edge with in_valid=1 and target bank wr_bank writable: write {din_r,din_i} to address bitrev(wr_idx), where bitrev reverses the LOG2N bits. Then increment wr_idx.
  - When wr_idx==N-1: set bank_full[wr_bank], toggle wr_bank, and wrap wr_idx to 0.
  - Writable means bank_full[wr_bank]==0, or the same edge releases that bank (see read side). Release-and-write on the same edge is legal and loses no sample.
  - If the bank is not writable: the sample is dropped, wr_idx is unchanged, and overflow is set to 1 until reset.
- Read side, FSM with 2 states:
  - IDLE: out_valid=0. If bank_full[rd_bank]==1, load entry rd_idx=0 into the output registers on the next edge, set out_valid=1, and go to STREAM.
  - STREAM: outputs are registered and hold stable while out_valid && !out_ready.
    - On acceptance with rd_idx<N-1: load entry rd_idx+1 on the same edge, out_valid stays 1, giving zero-bubble streaming.
    - On acceptance with rd_idx==N-1: clear bank_full[rd_bank] (the release), toggle rd_bank, set rd_idx=0.
    - After that release, if the other bank is already full, load its entry 0 on the same edge and remain in STREAM. Otherwise set out_valid=0 and go to IDLE.
  - out_last = (rd_idx==N-1) && out_valid.
- Latency: the edge that captures input index N-1 sets bank_full. Entry 0 is registered on the next edge, so out_valid rises 1 clock after the frame completes.
- Throughput: with out_ready held high, the output sustains 1 sample per clock. Continuous back-to-back input frames therefore never overflow.
- Data is passed through bit-exact; there is no arithmetic and no sign change.

Decomposition:
- Package fft_pkg holds:
  - typedef cplx_t as a struct {logic signed [DW-1:0] re, im}.
  - function bitrev(idx, LOG2N).
  - enum rd_state_t {IDLE, STREAM}.
  - Default constants FFT_DW=24 and FFT_LOG2N=4.
- One sub-module, fft_pingpong_ram: two banks, 1 write port and 1 async read port, bank-select inputs. It maps to flops or a dual-port macro.
- The write/read control and the FSM stay in fft_bitrev_reorder.

Test Plan:
- Single frame: N=16, in_valid for 16 cycles with din_r=bitrev(k), din_i=-bitrev(k) for k=0..15; out_ready=1. Required response: out_valid rises 1 clock after the 16th input, then dout_r=0..15 and dout_i=0..-15 on consecutive cycles, out_last only with dout_r=15, then out_valid=0.
- Back-to-back frames: 4 continuous frames, out_ready=1. Required response: 64 natural-order outputs with no gaps after the first, and overflow stays 0.
- Backpressure: toggle out_ready 1/0 each cycle during a frame. Required response: each sample is held stable while out_ready=0, no sample is duplicated or skipped, and out_last appears exactly once.
- Overflow: hold out_ready=0 and send 3 full frames. Required response: frames 0 and 1 are buffered, the first sample of frame 2 sets overflow=1 and all of frame 2 is dropped. After releasing out_ready, exactly frames 0 and 1 come out in order.
- Simultaneous release/write: arrange for the last output accept of bank 0 to fall on the same edge as input index 0 of a frame targeting bank 0. Required response: no drop, overflow=0, and the new frame is output correctly.
- Reset mid-operation: assert reset during input index 7 and again during output index 5. Required response: all outputs 0 immediately. After deassertion, a fresh frame is output correctly with no stale samples.
